// File: rtl/regfile_wb_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_scheduler_if
// Purpose  : Writeback bus between the execute/memory stages, decode and the
//            register-file write scheduler.
// Revision : 1.0  initial release
// ============================================================================
interface regfile_wb_scheduler_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  // ALU writeback source
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  // Load writeback source
  logic            ld_valid;
  logic [AW-1:0]   ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            ld_ready;
  // Decode issue / hazard check
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic [AW-1:0]   chk_rs1;
  logic [AW-1:0]   chk_rs2;
  logic            hazard;
  // Register-file write port
  logic            rf_reg_write;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_write_data;

  // Producer side: sources, decode, and the observer of the write port
  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output issue_valid, issue_rd, chk_rs1, chk_rs2,
    input  alu_ready, ld_ready, hazard,
    input  rf_reg_write, rf_rd, rf_write_data
  );

  // Scheduler side
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  issue_valid, issue_rd, chk_rs1, chk_rs2,
    output alu_ready, ld_ready, hazard,
    output rf_reg_write, rf_rd, rf_write_data
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_scheduler
// Purpose  : Arbitrates the single register-file write port between ALU and
//            load writebacks (load-first with ALU anti-starvation), and keeps
//            the pending-write scoreboard used by decode for RAW stalls.
// Revision : 1.0  initial release
// ============================================================================
module regfile_wb_scheduler #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int MAX_WAIT = 3
) (
  input  wire logic              clk,
  input  wire logic              reset,
  regfile_wb_scheduler_if.slave  bus
);

  localparam int            WW         = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] C_WAIT_MAX = WW'(MAX_WAIT);

  logic [WW-1:0]   wait_q, wait_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            we_q, we_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;

  logic            w_alu_pri;
  logic            w_alu_gnt;
  logic            w_ld_gnt;
  logic            w_wr;
  logic [AW-1:0]   w_gnt_rd;
  logic [XLEN-1:0] w_gnt_data;

  // Arbitration: load wins by default, ALU wins once it has been refused MAX_WAIT cycles
  always_comb begin
    w_alu_pri  = (wait_q == C_WAIT_MAX);
    w_ld_gnt   = !reset && bus.ld_valid  && !(bus.alu_valid && w_alu_pri);
    w_alu_gnt  = !reset && bus.alu_valid && !(bus.ld_valid && !w_alu_pri);
    w_gnt_rd   = w_alu_gnt ? bus.alu_rd   : bus.ld_rd;
    w_gnt_data = w_alu_gnt ? bus.alu_data : bus.ld_data;
    // x0 grants are accepted but never reach the register file
    w_wr       = (w_alu_gnt || w_ld_gnt) && (w_gnt_rd != '0);
  end

  // Next-state: starvation counter, scoreboard and write-port staging
  always_comb begin
    wait_d = wait_q;
    if (!bus.alu_valid || w_alu_gnt) begin
      wait_d = '0;
    end else if (wait_q != C_WAIT_MAX) begin
      wait_d = wait_q + 1'b1;
    end

    // Clear first, then set, so a same-cycle issue to the same register stays pending
    busy_d = busy_q;
    if (w_wr) begin
      busy_d[w_gnt_rd] = 1'b0;
    end
    if (bus.issue_valid && (bus.issue_rd != '0)) begin
      busy_d[bus.issue_rd] = 1'b1;
    end

    we_d   = w_wr;
    rd_d   = w_wr ? w_gnt_rd   : rd_q;
    data_d = w_wr ? w_gnt_data : data_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q <= '0;
      busy_q <= '0;
      we_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      wait_q <= wait_d;
      busy_q <= busy_d;
      we_q   <= we_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  // Outputs: handshake readies and hazard are combinational, write port is registered
  always_comb begin
    bus.alu_ready     = w_alu_gnt;
    bus.ld_ready      = w_ld_gnt;
    bus.hazard        = ((bus.chk_rs1 != '0) && busy_q[bus.chk_rs1]) ||
                        ((bus.chk_rs2 != '0) && busy_q[bus.chk_rs2]);
    bus.rf_reg_write  = we_q;
    bus.rf_rd         = rd_q;
    bus.rf_write_data = data_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_scheduler
// Purpose  : Scoreboard bench for regfile_wb_scheduler with directed scenarios
//            followed by randomized traffic against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wb_scheduler;
  localparam int XLEN     = 32;
  localparam int NREG     = 32;
  localparam int AW       = 5;
  localparam int MAX_WAIT = 3;

  typedef struct {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
    int              due;
  } wb_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_scheduler_if #(.XLEN(XLEN), .AW(AW)) bus ();

  regfile_wb_scheduler #(
    .XLEN(XLEN), .NREG(NREG), .AW(AW), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  wb_t exp_q[$];
  int  vectors = 0;
  int  errs    = 0;
  int  cyc     = 0;
  bit  mon_en  = 0;
  bit  m_busy[NREG];
  int  m_refused = 0;
  bit  last_ga = 0;
  bit  last_gl = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected writeback
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.rf_reg_write === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("rf_reg_write_unexpected", bus.rf_reg_write, 0);
        end else begin
          wb_t e;
          e = exp_q.pop_front();
          chk("rf_write_cycle", cyc, e.due);
          chk("rf_rd", bus.rf_rd, e.rd);
          chk("rf_write_data", bus.rf_write_data, e.data);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        chk("rf_reg_write_missing", bus.rf_reg_write, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus: predict grants/hazard from the current inputs, compare, advance model
  task automatic step();
    bit              ga, gl, haz;
    logic [AW-1:0]   grd;
    logic [XLEN-1:0] gd;
    @(negedge clk);
    ga = 0;
    gl = 0;
    if (!reset) begin
      if (bus.alu_valid && bus.ld_valid) begin
        if (m_refused >= MAX_WAIT) ga = 1;
        else gl = 1;
      end else begin
        ga = bus.alu_valid;
        gl = bus.ld_valid;
      end
    end
    haz = ((bus.chk_rs1 != 0) && m_busy[bus.chk_rs1]) ||
          ((bus.chk_rs2 != 0) && m_busy[bus.chk_rs2]);
    chk("alu_ready", bus.alu_ready, ga);
    chk("ld_ready", bus.ld_ready, gl);
    chk("hazard", bus.hazard, haz);
    if (reset) chk("rf_reg_write_in_reset", bus.rf_reg_write, 0);

    if (reset) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_refused = 0;
    end else begin
      if (bus.alu_valid && !ga) m_refused = (m_refused < MAX_WAIT) ? m_refused + 1 : MAX_WAIT;
      else m_refused = 0;
      if (ga || gl) begin
        grd = ga ? bus.alu_rd : bus.ld_rd;
        gd  = ga ? bus.alu_data : bus.ld_data;
        if (grd != 0) begin
          m_busy[grd] = 0;
          exp_q.push_back('{rd: grd, data: gd, due: cyc + 1});
        end
      end
      if (bus.issue_valid && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1;
    end
    last_ga = ga;
    last_gl = gl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    foreach (m_busy[i]) m_busy[i] = 0;
    bus.alu_valid = 1; bus.alu_rd = 5'd3; bus.alu_data = 32'h1111_1111;
    bus.ld_valid  = 1; bus.ld_rd  = 5'd2; bus.ld_data  = 32'h2222_2222;
    bus.issue_valid = 0; bus.issue_rd = 0;
    bus.chk_rs1 = 5'd2; bus.chk_rs2 = 5'd3;
    reset = 1;
    @(posedge clk);
    #1;
    mon_en = 1;

    // Reset held with both sources requesting
    step();
    bus.chk_rs1 = 5'd31; bus.chk_rs2 = 5'd1;
    step();
    reset = 0;
    bus.alu_valid = 0; bus.ld_valid = 0;
    step();

    // Lone ALU request
    bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
    step();
    bus.alu_valid = 0;
    step();

    // Both valid continuously: three load grants then the ALU
    bus.ld_valid  = 1; bus.ld_rd  = 5'd6; bus.ld_data  = 32'h0000_0606;
    bus.alu_valid = 1; bus.alu_rd = 5'd7; bus.alu_data = 32'h0000_0707;
    repeat (4) step();
    bus.alu_valid = 0;
    step();
    bus.ld_valid = 0;
    step();

    // RAW hazard held until the load to x9 writes back
    bus.issue_valid = 1; bus.issue_rd = 5'd9;
    step();
    bus.issue_valid = 0; bus.chk_rs1 = 5'd9; bus.chk_rs2 = 5'd0;
    step();
    step();
    bus.ld_valid = 1; bus.ld_rd = 5'd9; bus.ld_data = 32'h9999_0009;
    step();
    bus.ld_valid = 0;
    step();
    step();

    // Same-cycle issue and writeback to x4: the newer write stays pending
    bus.issue_valid = 1; bus.issue_rd = 5'd4;
    bus.ld_valid = 1; bus.ld_rd = 5'd4; bus.ld_data = 32'h4444_0004;
    step();
    bus.issue_valid = 0; bus.ld_valid = 0;
    bus.chk_rs1 = 5'd0; bus.chk_rs2 = 5'd4;
    step();
    bus.ld_valid = 1; bus.ld_data = 32'h4444_0044;
    step();
    bus.ld_valid = 0;
    step();

    // Writeback to x0 is accepted but never written
    bus.alu_valid = 1; bus.alu_rd = 5'd0; bus.alu_data = 32'h0000_1234;
    bus.chk_rs1 = 5'd0;
    step();
    bus.alu_valid = 0;
    step();
    step();

    // Randomized traffic; a source keeps its request until it is accepted
    repeat (3000) begin
      if (last_ga || !bus.alu_valid) begin
        bus.alu_valid = ($urandom_range(0, 3) != 0);
        bus.alu_rd    = AW'($urandom_range(0, 7));
        bus.alu_data  = $urandom;
      end
      if (last_gl || !bus.ld_valid) begin
        bus.ld_valid = ($urandom_range(0, 2) != 0);
        bus.ld_rd    = AW'($urandom_range(0, 7));
        bus.ld_data  = $urandom;
      end
      bus.issue_valid = ($urandom_range(0, 1) != 0);
      bus.issue_rd    = AW'($urandom_range(0, 7));
      bus.chk_rs1     = AW'($urandom_range(0, 7));
      bus.chk_rs2     = AW'($urandom_range(0, 31));
      step();
    end

    // Drain outstanding writebacks
    bus.alu_valid = 0; bus.ld_valid = 0; bus.issue_valid = 0;
    repeat (4) step();
    chk("writebacks_outstanding", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
`default_nettype wire
